mygo_chan_merge: RTL

Registered N-to-1 channel fan-in. It lets several goroutine senders share one channel by arbitrating among NUM_IN valid/ready sender ports with a round-robin policy. It sits directly upstream of the channel FIFO: its `out_*` port connects to the FIFO's `in_data`/`in_valid`/`in_ready` port. Each transfer carries the index of the winning sender so downstream select logic can identify the producer.

---
 rtl/mygo_chan_merge.sv | 77 +++++++
 1 files changed

// File: rtl/mygo_chan_merge.sv
// mygo_chan_merge: registered N-to-1 valid/ready fan-in with round-robin
// arbitration. Each output word carries the index of the sender that produced it.
module mygo_chan_merge #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 2,
  parameter int SEL_BITS = (NUM_IN <= 1) ? 1 : $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_BITS-1:0]     out_src
);

  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] grant_idx;
  logic [SEL_BITS-1:0] next_ptr;
  logic [WIDTH-1:0]    grant_data;
  logic                grant_any;
  logic                can_load;
  logic                accept;

  assign can_load = !out_valid || out_ready;
  assign accept   = grant_any && can_load;
  assign next_ptr = (grant_idx == SEL_BITS'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

  // Round-robin pick: scan rr_ptr..NUM_IN-1 first, then wrap to 0..rr_ptr-1.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      if (!grant_any && in_valid[j] && (j >= 32'(rr_ptr))) begin
        grant_any  = 1'b1;
        grant_idx  = SEL_BITS'(j);
        grant_data = in_data[j*WIDTH +: WIDTH];
      end
    end
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      if (!grant_any && in_valid[j] && (j < 32'(rr_ptr))) begin
        grant_any  = 1'b1;
        grant_idx  = SEL_BITS'(j);
        grant_data = in_data[j*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot ready to the winning sender, suppressed during reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      in_ready[j] = rst_n && accept && (grant_idx == SEL_BITS'(j));
    end
  end

  // Output register and pointer: load on accept, clear valid on plain drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_src   <= grant_idx;
      rr_ptr    <= next_ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
